// File: rtl/cpu_pkg.sv
// Shared opcode, ALU select and state encodings for the sequencer and the ALU.
// Optional STEP state exists only when CPU_SINGLE_STEP_EN is defined.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_INC  = 4'h3;
    localparam logic [3:0] OP_DEC  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU select codes equal the ALU opcodes so decode is a straight pass-through
    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = OP_ADD;
    localparam logic [3:0] ALU_SUB  = OP_SUB;
    localparam logic [3:0] ALU_INC  = OP_INC;
    localparam logic [3:0] ALU_DEC  = OP_DEC;
    localparam logic [3:0] ALU_AND  = OP_AND;
    localparam logic [3:0] ALU_OR   = OP_OR;
    localparam logic [3:0] ALU_NOT  = OP_NOT;
    localparam logic [3:0] ALU_SHL  = OP_SHL;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_IMM,
`ifdef CPU_SINGLE_STEP_EN
        ST_STEP,
`endif
        ST_HALT
    } state_t;

    // State entered once an instruction has fully retired
`ifdef CPU_SINGLE_STEP_EN
    localparam state_t ST_DONE = ST_STEP;
`else
    localparam state_t ST_DONE = ST_FETCH;
`endif

    typedef struct packed {
        logic       is_alu;
        logic       is_imm;
        logic       is_halt;
        logic       is_illegal;
        logic [3:0] alus;
    } dec_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

endpackage

// File: rtl/cpu_instr_dec.sv
// Combinational opcode classifier: opcode -> {is_alu, is_imm, is_halt, is_illegal, alus}.
// Zero latency, no flow control.
module cpu_instr_dec
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        if (is_alu_op(opcode)) begin
            dec.is_alu = 1'b1;
            dec.alus   = opcode;
        end else begin
            dec.alus = ALU_NONE;
            case (opcode)
                OP_NOP:                 ;
                OP_LDI, OP_JMP, OP_JZ:  dec.is_imm  = 1'b1;
                OP_HALT:                dec.is_halt = 1'b1;
                default:                dec.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute sequencer owning PC, IR and zero flag; CPU_SINGLE_STEP_EN adds a STEP gate.
// Latency: ALU/LDI/JMP/JZ 3 cycles, NOP 2; stalls on mem_rdy with a MEM_TIMEOUT bus-error escape.
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
`ifdef CPU_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       mem_rd,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       mem_rdy,
    input  logic [7:0] alu_dout,
    output logic [3:0] alus,
    output logic [1:0] rs_sel,
    output logic [1:0] rd_sel,
    output logic       reg_we,
    output logic       reg_wsrc,
    output logic       zflag,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err
);

    localparam int            CW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [7:0]    pc, pc_nxt;
    logic [7:0]    ir, ir_nxt;
    logic          zflag_nxt;
    logic          bus_err_nxt;
    logic [CW-1:0] tcnt, tcnt_nxt;
    dec_t          dec;

    cpu_instr_dec u_dec (
        .opcode (ir[7:4]),
        .dec    (dec)
    );

    assign mem_addr = pc;
    assign rs_sel   = ir[1:0];
    assign rd_sel   = ir[3:2];

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        zflag_nxt   = zflag;
        bus_err_nxt = bus_err;
        tcnt_nxt    = tcnt;
        mem_rd      = 1'b0;
        alus        = ALU_NONE;
        reg_we      = 1'b0;
        reg_wsrc    = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    ir_nxt    = mem_rdata;
                    pc_nxt    = pc + 8'd1;
                    tcnt_nxt  = '0;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec.is_alu) begin
                    state_nxt = ST_EXEC;
                end else if (dec.is_imm) begin
                    state_nxt = ST_IMM;
                end else if (dec.is_halt) begin
                    state_nxt = ST_HALT;
                end else begin
                    illegal   = dec.is_illegal;
                    state_nxt = ST_DONE;
                end
            end
            ST_EXEC: begin
                alus      = dec.alus;
                reg_we    = 1'b1;
                zflag_nxt = (alu_dout == 8'h00);
                state_nxt = ST_DONE;
            end
            ST_IMM: begin
                mem_rd = 1'b1;
                if (mem_rdy) begin
                    tcnt_nxt  = '0;
                    state_nxt = ST_DONE;
                    case (ir[7:4])
                        OP_LDI: begin
                            reg_we   = 1'b1;
                            reg_wsrc = 1'b1;
                            pc_nxt   = pc + 8'd1;
                        end
                        OP_JZ:   pc_nxt = zflag ? mem_rdata : pc + 8'd1;
                        default: pc_nxt = mem_rdata;
                    endcase
                end
            end
`ifdef CPU_SINGLE_STEP_EN
            ST_STEP: begin
                if (step) state_nxt = ST_FETCH;
            end
`endif
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_FETCH;
        endcase

        // Memory wait: the MEM_TIMEOUT-th unanswered cycle converts into a sticky bus error
        if ((state == ST_FETCH || state == ST_IMM) && !mem_rdy) begin
            if (tcnt == TMAX) begin
                bus_err_nxt = 1'b1;
                state_nxt   = ST_HALT;
            end else begin
                tcnt_nxt = tcnt + CW'(1);
            end
        end

        if (rst) begin
            mem_rd   = 1'b0;
            alus     = ALU_NONE;
            reg_we   = 1'b0;
            reg_wsrc = 1'b0;
            halted   = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            ir      <= 8'h00;
            zflag   <= 1'b0;
            bus_err <= 1'b0;
            tcnt    <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            zflag   <= zflag_nxt;
            bus_err <= bus_err_nxt;
            tcnt    <= tcnt_nxt;
        end
    end

endmodule
